mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between instruction fetch and the load/store unit. Owns the core's only memory bus, grants it to one requester at a time, and returns per-requester completion pulses. Data accesses have priority, with a bounded-starvation guard for fetch and a watchdog that aborts hung transactions. It generates the `fetch_stall` and `memory_done` signals consumed by the core control logic.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants taken while fetch waits before fetch is forced to win (1..15).
- `TIMEOUT`, default 255: busy cycles without `mem_ack_i` before abort (1..255); 0 disables the watchdog.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req_i` in 1: fetch request; held with `if_addr_i` until `if_done_o`.
- `if_addr_i` in 32: fetch address.
- `if_rdata_o` out 32: fetched word; valid with `if_done_o`, held until the next fetch done.
- `if_done_o` out 1: one-cycle fetch completion pulse.
- `d_req_i` in 1: data request; held with the `d_*` fields until `d_done_o`.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_addr_i` in 32: data address.
- `d_wdata_i` in 32: store data.
- `d_be_i` in 4: byte enables.
- `d_rdata_o` out 32: load data; valid with `d_done_o`, held until the next data done.
- `d_done_o` out 1: one-cycle data completion pulse (memory_done).
- `err_o` out 1: pulses together with a done that ended by timeout.
- `fetch_stall_o` out 1: `if_req_i & ~if_done_o` (combinational).
- `mem_req_o`, `mem_we_o` out 1: bus request and write enable.
- `mem_addr_o`, `mem_wdata_o` out 32: bus address and write data.
- `mem_be_o` out 4: bus byte enables.
- `mem_ack_i` in 1: one-cycle ack; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in 32: bus read data.

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- In IDLE, a requester's req is ignored in the cycle its own done is high. This prevents re-issue from a still-asserted req.
- IDLE arbitration uses eligible requests only:
  - data only: go to D_BUSY.
  - fetch only: go to IF_BUSY.
  - both: IF_BUSY if `streak == STARVE_LIMIT`, else D_BUSY.
- On grant, latch addr, we, wdata and be into the `mem_*` registers. Fetch grants use we=0 and be=4'hF.
- `mem_req_o` = 1 in every BUSY cycle and 0 in IDLE. The `mem_*` fields are stable while `mem_req_o` = 1.
- `streak` is a 4-bit counter:
  - +1 on a data grant while `if_req_i` is eligible; saturates at `STARVE_LIMIT`.
  - cleared on any fetch grant.
- BUSY with `mem_ack_i` = 1:
  - capture `mem_rdata_i` into the owner's rdata register;
  - pulse the owner's done next cycle;
  - return to IDLE.
- Watchdog `wcnt` (8-bit):
  - cleared on grant; +1 each BUSY cycle without ack.
  - When `wcnt == TIMEOUT` with no ack: return to IDLE, pulse owner done and `err_o` next cycle, set owner rdata = 0.
- `mem_ack_i` while `mem_req_o` = 0 is ignored, including a late ack after an abort.
- Stores also update `d_rdata_o` from `mem_rdata_i`; the value is don't-care to the core.

## Timing
- Reset (async assert): state IDLE, streak = 0, wcnt = 0. All outputs 0: `mem_*`, rdata, done, `err_o`. `fetch_stall_o` follows `if_req_i`.
- Reset asserted mid-transaction aborts it with no done pulse. The bus sees `mem_req_o` fall asynchronously.
- Request eligible in IDLE at cycle 0 → `mem_req_o` = 1 from cycle 1.
- Ack at cycle k (k ≥ 1) → `mem_req_o` = 0 and done = 1 at cycle k+1. Minimum request-to-done latency is 2 cycles.
- Back-to-back grants: the next grant is sampled in the done cycle (k+1), so the next `mem_req_o` rises at k+2. Bus idle gap is 1 cycle.
- Timeout: with no ack during busy cycles 1..TIMEOUT+1, done and `err_o` = 1 at cycle TIMEOUT+2.
- Requests arriving during BUSY wait; they are evaluated in IDLE.

## Test plan
- Single load: `d_req_i`=1, addr 0x100, ack at cycle 3 with rdata 0xDEADBEEF → `mem_req_o` high cycles 1–3, `d_done_o` at cycle 4, `d_rdata_o`=0xDEADBEEF, `err_o`=0.
- Store pass-through: `d_we_i`=1, addr 0x204, wdata 0x12345678, be 4'b0011 → `mem_*` carries exactly those values while `mem_req_o`=1; `d_done_o` one cycle after ack.
- Contention: both req asserted in the same cycle → data granted first; fetch granted immediately after the data done; `fetch_stall_o`=1 until `if_done_o`.
- Starvation guard: fetch held high, data re-requested every done, STARVE_LIMIT=4 → grants D,D,D,D,IF; streak then 0.
- Timeout: TIMEOUT=5, never ack → done + `err_o` at cycle 7, rdata=0; a late ack at cycle 8 is ignored and no second done occurs.
- Reset mid-operation: deassert `rst_n` in the cycle after `mem_req_o` rises → all outputs 0 immediately; after release, a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch and load/store with starvation guard and watchdog
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_done_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic [31:0] d_rdata_o,
  output logic        d_done_o,
  output logic        err_o,
  output logic        fetch_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WDOG_MAX   = 8'(TIMEOUT);
  localparam bit         WDOG_EN    = (TIMEOUT != 0);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  streak;
  logic [7:0]  wcnt;
  logic        if_elig;
  logic        d_elig;
  logic        grant_if;
  logic        grant_d;
  logic        busy;
  logic        ack_hit;
  logic        timeout_hit;
  logic        finish;

  // A requester whose done is high this cycle still shows its old req; mask it.
  assign if_elig = if_req_i & ~if_done_o;
  assign d_elig  = d_req_i  & ~d_done_o;

  assign busy        = (state != IDLE);
  assign ack_hit     = busy & mem_ack_i;
  assign timeout_hit = WDOG_EN & busy & ~mem_ack_i & (wcnt == WDOG_MAX);
  assign finish      = ack_hit | timeout_hit;

  assign mem_req_o     = busy;
  assign fetch_stall_o = if_req_i & ~if_done_o;

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetch has waited through STARVE_LIMIT data grants.
        if (d_elig && !(if_elig && (streak == STREAK_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (grant_if) begin
      streak <= 4'd0;
    end else if (grant_d && if_elig && (streak != STREAK_MAX)) begin
      streak <= streak + 4'd1;
    end
  end

  // Saturating so a disabled watchdog never wraps back into a false match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 8'd0;
    end else if (grant_if || grant_d) begin
      wcnt <= 8'd0;
    end else if (busy && !mem_ack_i && !timeout_hit && (wcnt != 8'hFF)) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      mem_be_o    <= 4'd0;
    end else if (grant_d) begin
      mem_we_o    <= d_we_i;
      mem_addr_o  <= d_addr_i;
      mem_wdata_o <= d_wdata_i;
      mem_be_o    <= d_be_i;
    end else if (grant_if) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= 32'd0;
      mem_be_o    <= 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_o <= 32'd0;
      d_rdata_o  <= 32'd0;
      if_done_o  <= 1'b0;
      d_done_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if_done_o <= (state == IF_BUSY) && finish;
      d_done_o  <= (state == D_BUSY)  && finish;
      err_o     <= timeout_hit;
      if (state == IF_BUSY) begin
        if (ack_hit) begin
          if_rdata_o <= mem_rdata_i;
        end else if (timeout_hit) begin
          if_rdata_o <= 32'd0;
        end
      end
      if (state == D_BUSY) begin
        if (ack_hit) begin
          d_rdata_o <= mem_rdata_i;
        end else if (timeout_hit) begin
          d_rdata_o <= 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_done_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_done_o;
  logic        err_o;
  logic        fetch_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int vecs;
  int errs;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_rdata_o    (if_rdata_o),
    .if_done_o     (if_done_o),
    .d_req_i       (d_req_i),
    .d_we_i        (d_we_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_be_i        (d_be_i),
    .d_rdata_o     (d_rdata_o),
    .d_done_o      (d_done_o),
    .err_o         (err_o),
    .fetch_stall_o (fetch_stall_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    rst_n       = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = 32'd0;
    d_req_i     = 1'b0;
    d_we_i      = 1'b0;
    d_addr_i    = 32'd0;
    d_wdata_i   = 32'd0;
    d_be_i      = 4'd0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'd0;

    // reset state
    #12;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_d_done", 32'(d_done_o), 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stall_lo", 32'(fetch_stall_o), 32'd0);
    if_req_i = 1'b1;
    #1;
    chk("rst_stall_hi", 32'(fetch_stall_o), 32'd1);
    if_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // single load, ack at cycle 3
    d_req_i  = 1'b1;
    d_addr_i = 32'h100;
    tick();
    chk("ld_req_c1", 32'(mem_req_o), 32'd1);
    chk("ld_addr", mem_addr_o, 32'h100);
    chk("ld_we", 32'(mem_we_o), 32'd0);
    tick();
    chk("ld_req_c2", 32'(mem_req_o), 32'd1);
    tick();
    chk("ld_req_c3", 32'(mem_req_o), 32'd1);
    chk("ld_nodone_c3", 32'(d_done_o), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b0;
    chk("ld_done_c4", 32'(d_done_o), 32'd1);
    chk("ld_rdata", d_rdata_o, 32'hDEADBEEF);
    chk("ld_err", 32'(err_o), 32'd0);
    chk("ld_req_c4", 32'(mem_req_o), 32'd0);
    d_req_i = 1'b0;
    tick();
    chk("ld_done_c5", 32'(d_done_o), 32'd0);

    // store pass-through
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h204;
    d_wdata_i = 32'h12345678;
    d_be_i    = 4'b0011;
    tick();
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_addr", mem_addr_o, 32'h204);
    chk("st_wdata", mem_wdata_o, 32'h12345678);
    chk("st_be", 32'(mem_be_o), 32'h3);
    tick();
    chk("st_req_c2", 32'(mem_req_o), 32'd1);
    chk("st_wdata_c2", mem_wdata_o, 32'h12345678);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hA5A5A5A5;
    tick();
    mem_ack_i = 1'b0;
    chk("st_done", 32'(d_done_o), 32'd1);
    chk("st_req_c3", 32'(mem_req_o), 32'd0);
    d_req_i = 1'b0;
    d_we_i  = 1'b0;
    tick();

    // contention: data first, fetch right after data done
    d_req_i   = 1'b1;
    d_addr_i  = 32'h300;
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    tick();
    chk("ct_d_first", mem_addr_o, 32'h300);
    chk("ct_stall_c1", 32'(fetch_stall_o), 32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h11;
    tick();
    mem_ack_i = 1'b0;
    chk("ct_d_done", 32'(d_done_o), 32'd1);
    chk("ct_stall_c2", 32'(fetch_stall_o), 32'd1);
    d_req_i = 1'b0;
    tick();
    chk("ct_if_grant", mem_addr_o, 32'h40);
    chk("ct_if_be", 32'(mem_be_o), 32'hF);
    chk("ct_if_we", 32'(mem_we_o), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h22;
    tick();
    mem_ack_i = 1'b0;
    chk("ct_if_done", 32'(if_done_o), 32'd1);
    chk("ct_if_rdata", if_rdata_o, 32'h22);
    chk("ct_stall_c4", 32'(fetch_stall_o), 32'd0);
    if_req_i = 1'b0;
    tick();

    // starvation guard: four data grants with fetch waiting, then fetch wins
    if_addr_i = 32'h80;
    d_req_i   = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if_req_i = 1'b1;
      d_addr_i = 32'h500 + 32'(r) * 32'd4;
      tick();
      chk("sv_d_grant", mem_addr_o, 32'h500 + 32'(r) * 32'd4);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h44;
      tick();
      mem_ack_i = 1'b0;
      if_req_i  = 1'b0;
      chk("sv_d_done", 32'(d_done_o), 32'd1);
      tick();
      chk("sv_idle", 32'(mem_req_o), 32'd0);
    end
    chk("sv_streak_max", 32'(dut.streak), 32'd4);
    if_req_i = 1'b1;
    tick();
    chk("sv_if_wins", mem_addr_o, 32'h80);
    chk("sv_if_be", 32'(mem_be_o), 32'hF);
    chk("sv_streak_clr", 32'(dut.streak), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h33;
    tick();
    mem_ack_i = 1'b0;
    chk("sv_if_done", 32'(if_done_o), 32'd1);
    if_req_i = 1'b0;
    tick();
    chk("sv_d_after", mem_addr_o, 32'h50C);
    chk("sv_streak_hold", 32'(dut.streak), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h44;
    tick();
    mem_ack_i = 1'b0;
    d_req_i   = 1'b0;
    tick();

    // watchdog: TIMEOUT=5, never ack
    d_req_i  = 1'b1;
    d_addr_i = 32'h600;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("to_busy", 32'(mem_req_o), 32'd1);
      chk("to_nodone", 32'(d_done_o), 32'd0);
    end
    tick();
    chk("to_done_c7", 32'(d_done_o), 32'd1);
    chk("to_err_c7", 32'(err_o), 32'd1);
    chk("to_rdata", d_rdata_o, 32'd0);
    chk("to_req_c7", 32'(mem_req_o), 32'd0);
    d_req_i = 1'b0;
    tick();
    chk("to_done_c8", 32'(d_done_o), 32'd0);
    chk("to_err_c8", 32'(err_o), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF;
    tick();
    mem_ack_i = 1'b0;
    chk("late_done", 32'(d_done_o), 32'd0);
    chk("late_err", 32'(err_o), 32'd0);
    chk("late_rdata", d_rdata_o, 32'd0);
    chk("late_req", 32'(mem_req_o), 32'd0);

    // reset mid-transaction, then a fresh fetch
    if_req_i  = 1'b1;
    if_addr_i = 32'h900;
    tick();
    chk("mr_req_c1", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_req_async", 32'(mem_req_o), 32'd0);
    chk("mr_addr", mem_addr_o, 32'd0);
    chk("mr_be", 32'(mem_be_o), 32'd0);
    chk("mr_if_rdata", if_rdata_o, 32'd0);
    chk("mr_if_done", 32'(if_done_o), 32'd0);
    chk("mr_stall", 32'(fetch_stall_o), 32'd1);
    tick();
    chk("mr_req_held", 32'(mem_req_o), 32'd0);
    chk("mr_no_done", 32'(if_done_o), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_fresh_req", 32'(mem_req_o), 32'd1);
    chk("mr_fresh_addr", mem_addr_o, 32'h900);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h77;
    tick();
    mem_ack_i = 1'b0;
    chk("mr_fresh_done", 32'(if_done_o), 32'd1);
    chk("mr_fresh_rdata", if_rdata_o, 32'h77);
    if_req_i = 1'b0;
    tick();
    chk("mr_done_clr", 32'(if_done_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
